fetch_unit: RTL

- Instruction-fetch stage directly upstream of the byte-addressable synchronous instruction memory: holds the PC, drives the memory byte address, and computes next-PC from sequential, branch and jump requests.
- Tracks the one-cycle memory read latency and pairs each returned 32-bit instruction with its PC and a valid bit for the decode stage.
- Squashes wrong-path fetches on redirect; supports stall and halt-word detection.

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 109 ++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: memory port, redirect inputs and decode-side outputs
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  stall;
    logic                  branch_taken;
    logic [15:0]           branch_offset;
    logic                  jump;
    logic [25:0]           jump_index;
    logic [31:0]           instruction_in;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           if_instruction;
    logic [ADDR_WIDTH-1:0] if_pc;
    logic                  if_valid;
    logic                  halted;

    // fetch unit side
    modport master (
        input  stall, branch_taken, branch_offset, jump, jump_index, instruction_in,
        output mem_address, if_instruction, if_pc, if_valid, halted
    );

    // memory / decode / environment side
    modport slave (
        output stall, branch_taken, branch_offset, jump, jump_index, instruction_in,
        input  mem_address, if_instruction, if_pc, if_valid, halted
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with redirect, stall and halt; optional FETCH_PERF_COUNT_EN counters
module fetch_unit #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          RESET_PC   = 0,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic         clock,
    input  logic         reset,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [15:0]  fetch_count,
    output logic [15:0]  stall_count
`endif
);
    typedef enum logic {RUN, HALTED} state_t;

    localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(4);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic                  inflight_valid_q, inflight_valid_d;

    logic                  if_valid;
    logic                  halt_hit;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [31:0]           branch_disp;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] fetch_address;
    logic                  unused_bits;

    assign if_valid      = inflight_valid_q && (state_q == RUN);
    assign halt_hit      = if_valid && (bus.instruction_in == HALT_WORD);
    assign redirect      = if_valid && (bus.jump || bus.branch_taken);
    assign pc_plus4      = inflight_pc_q + WORD_STEP;
    assign branch_disp   = {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
    assign branch_target = pc_plus4 + branch_disp[ADDR_WIDTH-1:0];
    assign jump_target   = {bus.jump_index[ADDR_WIDTH-3:0], 2'b00};
    assign target        = bus.jump ? jump_target : branch_target;
    assign unused_bits   = ^{bus.jump_index[25:ADDR_WIDTH-2], branch_disp[31:ADDR_WIDTH]};

    assign bus.mem_address    = fetch_address;
    assign bus.if_pc          = inflight_pc_q;
    assign bus.if_valid       = if_valid;
    assign bus.if_instruction = if_valid ? bus.instruction_in : 32'h0;
    assign bus.halted         = (state_q == HALTED);

    // Next-fetch selection: the memory address is the mux output so a redirect
    // fetches its target in the same cycle, and a stall re-reads the held word.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        inflight_pc_d    = inflight_pc_q;
        inflight_valid_d = inflight_valid_q;
        fetch_address    = pc_q;
        if (state_q == RUN) begin
            if (halt_hit) begin
                state_d          = HALTED;
                inflight_valid_d = 1'b0;
            end else if (redirect) begin
                fetch_address    = target;
                pc_d             = target + WORD_STEP;
                inflight_pc_d    = target;
                inflight_valid_d = 1'b1;
            end else if (bus.stall) begin
                fetch_address    = inflight_pc_q;
            end else begin
                inflight_pc_d    = pc_q;
                inflight_valid_d = 1'b1;
                pc_d             = pc_q + WORD_STEP;
            end
        end
    end

    // State, PC and in-flight fetch registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= RUN;
            pc_q             <= RESET_ADDR;
            inflight_pc_q    <= RESET_ADDR;
            inflight_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_valid_q <= inflight_valid_d;
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    // Saturating fetch/stall counters, frozen once halted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_count <= 16'h0;
            stall_count <= 16'h0;
        end else if (state_q == RUN) begin
            if (if_valid && !bus.stall && !halt_hit && (fetch_count != 16'hFFFF))
                fetch_count <= fetch_count + 16'h1;
            if (bus.stall && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'h1;
        end
    end
`endif
endmodule
